// File: rtl/quad_pkg.sv
// Shared types for the quadrature decoder: the phase pair {A,B}, the four
// Gray phase constants, the counter direction encoding, and a helper that
// classifies one phase transition.
package quad_pkg;

  typedef logic [1:0] phase_t;  // {A, B}

  localparam phase_t PH_00 = 2'b00;
  localparam phase_t PH_01 = 2'b01;
  localparam phase_t PH_11 = 2'b11;
  localparam phase_t PH_10 = 2'b10;

  // Same encoding as the up/down counter's direction input.
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef enum logic [1:0] {
    MV_NONE = 2'd0,
    MV_UP   = 2'd1,
    MV_ILL  = 2'd2,
    MV_DN   = 2'd3
  } move_t;

  // Up order is 00->01->11->10->00, down is the reverse; two bits changing
  // at once is illegal.
  function automatic move_t classify(input phase_t prev, input phase_t cur);
    move_t mv;
    mv = MV_ILL;
    if (prev == cur) begin
      mv = MV_NONE;
    end else begin
      case ({prev, cur})
        {PH_00, PH_01}, {PH_01, PH_11}, {PH_11, PH_10}, {PH_10, PH_00}: mv = MV_UP;
        {PH_00, PH_10}, {PH_10, PH_11}, {PH_11, PH_01}, {PH_01, PH_00}: mv = MV_DN;
        default: mv = MV_ILL;
      endcase
    end
    return mv;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous input bit; clears to 0 on reset.
module sync2 (
  input  logic CLK,
  input  logic ResetN,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage shift register to resolve metastability.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes A/B, optionally glitch-filters them,
// and turns Gray phase transitions into a wrapping position count with
// direction, step pulse and a sticky illegal-transition flag.
// Optional glitch filter: define QUAD_FILTER_EN.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int FILT_CYCLES = 3
) (
  input  logic             CLK,
  input  logic             ResetN,
  input  logic             A,
  input  logic             B,
  input  logic             Clear,
  output logic [WIDTH-1:0] Q,
  output logic             DNUP,
  output logic             Step,
  output logic             Err
);

  if (FILT_CYCLES < 2 || FILT_CYCLES > 15) begin : g_filt_range
    $error("quad_decoder: FILT_CYCLES must be in 2..15");
  end

  // Cycles after reset release until cur reflects the pins; until then prev
  // just tracks cur so an idle non-00 input is absorbed without a count.
`ifdef QUAD_FILTER_EN
  localparam logic [2:0] WARM_DONE = 3'd4;
`else
  localparam logic [2:0] WARM_DONE = 3'd3;
`endif

  logic   a_s;
  logic   b_s;
  phase_t raw;
  phase_t cur;
  phase_t prev;
  logic [2:0] warm;
  logic   ready;
  move_t  mv;

  sync2 u_sync_a (.CLK(CLK), .ResetN(ResetN), .d(A), .q(a_s));
  sync2 u_sync_b (.CLK(CLK), .ResetN(ResetN), .d(B), .q(b_s));

  assign raw   = {a_s, b_s};
  assign ready = (warm == WARM_DONE);

  // Warm-up counter: saturates once the synchronized sample is trustworthy.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      warm <= 3'd0;
    end else if (!ready) begin
      warm <= warm + 3'd1;
    end
  end

`ifdef QUAD_FILTER_EN
  localparam logic [3:0] FILT_LAST = 4'(FILT_CYCLES - 1);

  logic [3:0] cnt_a;
  logic [3:0] cnt_b;

  // Per-phase filter: cur follows a bit only after FILT_CYCLES consecutive
  // samples that differ from it; during warm-up cur tracks raw directly.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      cur   <= PH_00;
      cnt_a <= 4'd0;
      cnt_b <= 4'd0;
    end else if (!ready) begin
      cur   <= raw;
      cnt_a <= 4'd0;
      cnt_b <= 4'd0;
    end else begin
      if (raw[1] != cur[1]) begin
        if (cnt_a == FILT_LAST) begin
          cur[1] <= raw[1];
          cnt_a  <= 4'd0;
        end else begin
          cnt_a <= cnt_a + 4'd1;
        end
      end else begin
        cnt_a <= 4'd0;
      end
      if (raw[0] != cur[0]) begin
        if (cnt_b == FILT_LAST) begin
          cur[0] <= raw[0];
          cnt_b  <= 4'd0;
        end else begin
          cnt_b <= cnt_b + 4'd1;
        end
      end else begin
        cnt_b <= 4'd0;
      end
    end
  end
`else
  assign cur = raw;
`endif

  assign mv = classify(prev, cur);

  // Decode register: Clear wins over any step; prev always follows cur.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      prev <= PH_00;
      Q    <= '0;
      DNUP <= DIR_UP;
      Step <= 1'b0;
      Err  <= 1'b0;
    end else begin
      prev <= cur;
      Step <= 1'b0;
      if (Clear) begin
        Q   <= '0;
        Err <= 1'b0;
      end else if (ready) begin
        case (mv)
          MV_UP: begin
            Q    <= Q + WIDTH'(1);
            DNUP <= DIR_UP;
            Step <= 1'b1;
          end
          MV_DN: begin
            Q    <= Q - WIDTH'(1);
            DNUP <= DIR_DN;
            Step <= 1'b1;
          end
          MV_ILL:  Err <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: directed scenarios plus a randomized walk, all
// checked against a position model built from the Gray step table.
`timescale 1ns/1ps
module tb_quad_decoder;

  localparam int WIDTH = 4;
  localparam int FILT  = 3;
  localparam int MODV  = 1 << WIDTH;
`ifdef QUAD_FILTER_EN
  localparam int LAT = 2 + FILT + 1;
`else
  localparam int LAT = 3;
`endif

  // ---------------- clock / reset ----------------
  logic CLK    = 1'b0;
  logic ResetN = 1'b0;
  logic A      = 1'b0;
  logic B      = 1'b0;
  logic Clear  = 1'b0;
  logic [WIDTH-1:0] Q;
  logic DNUP;
  logic Step;
  logic Err;

  always #5 CLK = ~CLK;

  quad_decoder #(.WIDTH(WIDTH), .FILT_CYCLES(FILT)) dut (
    .CLK(CLK), .ResetN(ResetN), .A(A), .B(B), .Clear(Clear),
    .Q(Q), .DNUP(DNUP), .Step(Step), .Err(Err)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  logic [1:0] up_seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  int         m_q;
  logic       m_dir;
  logic       m_err;
  logic [1:0] m_prev;
  logic [WIDTH-1:0] exp_q [$];

  function automatic int seq_index(input logic [1:0] p);
    for (int i = 0; i < 4; i++) if (up_seq[i] == p) return i;
    return 0;
  endfunction

  function automatic logic [1:0] phase_at(input int idx);
    return up_seq[((idx % 4) + 4) % 4];
  endfunction

  task automatic model_reset(input logic [1:0] pins);
    m_q = 0; m_dir = 1'b0; m_err = 1'b0; m_prev = pins;
  endtask

  task automatic model_move(input logic [1:0] nxt, output int exp_step);
    int d;
    d = (seq_index(nxt) - seq_index(m_prev) + 4) % 4;
    exp_step = 0;
    if (d == 1) begin
      m_q = (m_q + 1) % MODV; m_dir = 1'b0; exp_step = 1;
    end else if (d == 3) begin
      m_q = (m_q + MODV - 1) % MODV; m_dir = 1'b1; exp_step = 1;
    end else if (d == 2) begin
      m_err = 1'b1;
    end
    m_prev = nxt;
    exp_q.push_back(WIDTH'(m_q));
  endtask

  // ---------------- driver tasks ----------------
  // Drive a phase pair at a falling edge, then watch Step for LAT+2 cycles.
  task automatic drive_phase(input logic [1:0] p, output int hi_cnt, output int hi_at);
    hi_cnt = 0; hi_at = -1;
    @(negedge CLK);
    A = p[1]; B = p[0];
    for (int i = 1; i <= LAT + 2; i++) begin
      @(negedge CLK);
      if (Step === 1'b1) begin
        hi_cnt++;
        if (hi_at < 0) hi_at = i;
      end
    end
  endtask

  task automatic pulse_clear();
    @(negedge CLK); Clear = 1'b1;
    @(negedge CLK); Clear = 1'b0;
    m_q = 0; m_err = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    ResetN = 1'b0; A = 1'b0; B = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (Q !== '0)     begin failures++; $display("FAIL reset_q got=%0h exp=0", Q); end
    checks++; if (DNUP !== 1'b0) begin failures++; $display("FAIL reset_dnup got=%b exp=0", DNUP); end
    checks++; if (Step !== 1'b0) begin failures++; $display("FAIL reset_step got=%b exp=0", Step); end
    checks++; if (Err !== 1'b0)  begin failures++; $display("FAIL reset_err got=%b exp=0", Err); end
    ResetN = 1'b1;
    repeat (8) @(negedge CLK);
    model_reset(2'b00);
  endtask

  task automatic test_up();
    int hc, ha, es;
    for (int i = 1; i <= 4; i++) begin
      model_move(phase_at(i), es);
      drive_phase(phase_at(i), hc, ha);
      checks++; if (hc !== 1 || ha !== LAT) begin failures++; $display("FAIL up_step%0d pulses=%0d at=%0d exp=1 at=%0d", i, hc, ha, LAT); end
    end
    checks++; if (Q !== WIDTH'(m_q)) begin failures++; $display("FAIL up_q got=%0h exp=%0h", Q, m_q); end
    checks++; if (DNUP !== 1'b0)     begin failures++; $display("FAIL up_dnup got=%b exp=0", DNUP); end
    checks++; if (Err !== 1'b0)      begin failures++; $display("FAIL up_err got=%b exp=0", Err); end
  endtask

  task automatic test_wrap();
    int hc, ha, es, total;
    pulse_clear();
    @(negedge CLK);
    checks++; if (Q !== '0) begin failures++; $display("FAIL wrap_clear_q got=%0h exp=0", Q); end
    model_move(2'b10, es);
    drive_phase(2'b10, hc, ha);
    checks++; if (Q !== WIDTH'(m_q) || m_q != MODV - 1) begin failures++; $display("FAIL wrap_down_q got=%0h exp=%0h", Q, MODV - 1); end
    checks++; if (DNUP !== 1'b1) begin failures++; $display("FAIL wrap_down_dnup got=%b exp=1", DNUP); end
    total = 0;
    for (int i = 4; i < 20; i++) begin
      model_move(phase_at(i), es);
      drive_phase(phase_at(i), hc, ha);
      total += hc;
    end
    checks++; if (total !== 16) begin failures++; $display("FAIL wrap_up_pulses got=%0d exp=16", total); end
    checks++; if (Q !== WIDTH'(m_q)) begin failures++; $display("FAIL wrap_up_q got=%0h exp=%0h", Q, m_q); end
    checks++; if (DNUP !== 1'b0) begin failures++; $display("FAIL wrap_up_dnup got=%b exp=0", DNUP); end
  endtask

  task automatic test_err();
    int hc, ha, es, base;
    base = seq_index(m_prev);
    // walk forward to phase 01
    while (m_prev != 2'b01) begin
      base++;
      model_move(phase_at(base), es);
      drive_phase(phase_at(base), hc, ha);
    end
    model_move(2'b10, es);
    drive_phase(2'b10, hc, ha);
    checks++; if (Err !== 1'b1)      begin failures++; $display("FAIL err_set got=%b exp=1", Err); end
    checks++; if (hc !== 0)          begin failures++; $display("FAIL err_step pulses=%0d exp=0", hc); end
    checks++; if (Q !== WIDTH'(m_q)) begin failures++; $display("FAIL err_q got=%0h exp=%0h", Q, m_q); end
    model_move(2'b00, es); drive_phase(2'b00, hc, ha);
    model_move(2'b01, es); drive_phase(2'b01, hc, ha);
    checks++; if (Err !== 1'b1)      begin failures++; $display("FAIL err_sticky got=%b exp=1", Err); end
    checks++; if (Q !== WIDTH'(m_q)) begin failures++; $display("FAIL err_after_q got=%0h exp=%0h", Q, m_q); end
    pulse_clear();
    @(negedge CLK);
    checks++; if (Q !== '0 || Err !== 1'b0) begin failures++; $display("FAIL err_clear q=%0h err=%b exp q=0 err=0", Q, Err); end
  endtask

  task automatic test_clear_step();
    int hc, ha, es;
    // pins sit at 01; next up phase is 11
    @(negedge CLK);
    A = 1'b1; B = 1'b1;
    repeat (LAT - 1) @(negedge CLK);
    Clear = 1'b1;
    @(negedge CLK);
    Clear = 1'b0;
    m_prev = 2'b11; m_q = 0; m_err = 1'b0;
    checks++; if (Step !== 1'b0 || Q !== '0) begin failures++; $display("FAIL clear_step step=%b q=%0h exp step=0 q=0", Step, Q); end
    repeat (3) @(negedge CLK);
    model_move(2'b10, es);
    drive_phase(2'b10, hc, ha);
    checks++; if (Q !== WIDTH'(m_q) || hc !== 1) begin failures++; $display("FAIL clear_next q=%0h pulses=%0d exp q=%0h pulses=1", Q, hc, m_q); end
  endtask

  task automatic test_random();
    int hc, ha, es, r, idx;
    logic [1:0] nxt;
    logic [WIDTH-1:0] want;
    for (int n = 0; n < 40; n++) begin
      idx = seq_index(m_prev);
      r = $urandom_range(0, 9);
      if (r <= 3)      nxt = phase_at(idx + 1);
      else if (r <= 7) nxt = phase_at(idx - 1);
      else if (r == 8) nxt = m_prev;
      else             nxt = phase_at(idx + 2);
      model_move(nxt, es);
      drive_phase(nxt, hc, ha);
      want = exp_q.pop_back();
      checks++; if (hc !== es || (es == 1 && ha !== LAT)) begin failures++; $display("FAIL rand_step n=%0d pulses=%0d at=%0d exp=%0d", n, hc, ha, es); end
      checks++; if (Q !== want)    begin failures++; $display("FAIL rand_q n=%0d got=%0h exp=%0h", n, Q, want); end
      checks++; if (DNUP !== m_dir) begin failures++; $display("FAIL rand_dnup n=%0d got=%b exp=%b", n, DNUP, m_dir); end
      checks++; if (Err !== m_err)  begin failures++; $display("FAIL rand_err n=%0d got=%b exp=%b", n, Err, m_err); end
      if (n % 10 == 9) pulse_clear();
    end
  endtask

  task automatic test_reset_idle();
    int hc, ha, es, stray;
    // make sure the count is nonzero before reset
    if (m_q == 0) begin
      model_move(phase_at(seq_index(m_prev) + 1), es);
      drive_phase(m_prev, hc, ha);
    end
    @(negedge CLK);
    A = 1'b1; B = 1'b1;
    #2 ResetN = 1'b0;
    #1;
    checks++; if (Q !== '0 || Step !== 1'b0 || Err !== 1'b0 || DNUP !== 1'b0) begin failures++; $display("FAIL async_reset q=%0h step=%b err=%b dnup=%b exp all 0", Q, Step, Err, DNUP); end
    repeat (3) @(negedge CLK);
    ResetN = 1'b1;
    model_reset(2'b11);
    stray = 0;
    repeat (12) begin @(negedge CLK); if (Step === 1'b1) stray++; end
    checks++; if (stray !== 0 || Q !== '0 || Err !== 1'b0) begin failures++; $display("FAIL idle11_release steps=%0d q=%0h err=%b exp 0", stray, Q, Err); end
    model_move(2'b10, es);
    drive_phase(2'b10, hc, ha);
    checks++; if (Q !== WIDTH'(1) || DNUP !== 1'b0 || hc !== 1) begin failures++; $display("FAIL idle11_step q=%0h dnup=%b pulses=%0d exp q=1 dnup=0 pulses=1", Q, DNUP, hc); end
    // reset in the middle of a step in flight
    @(negedge CLK);
    A = 1'b0; B = 1'b0;
    @(negedge CLK);
    ResetN = 1'b0;
    repeat (2) @(negedge CLK);
    ResetN = 1'b1;
    model_reset(2'b00);
    stray = 0;
    repeat (12) begin @(negedge CLK); if (Step === 1'b1) stray++; end
    checks++; if (stray !== 0 || Q !== '0 || Err !== 1'b0) begin failures++; $display("FAIL midstep_reset steps=%0d q=%0h err=%b exp 0", stray, Q, Err); end
  endtask

`ifdef QUAD_FILTER_EN
  task automatic test_filter();
    int hc, ha, es, stray;
    logic [WIDTH-1:0] before;
    before = Q;
    @(negedge CLK); A = ~m_prev[1];
    repeat (2) @(negedge CLK);
    A = m_prev[1];
    stray = 0;
    repeat (12) begin @(negedge CLK); if (Step === 1'b1) stray++; end
    checks++; if (stray !== 0 || Q !== before) begin failures++; $display("FAIL filt_glitch steps=%0d q=%0h exp 0 q=%0h", stray, Q, before); end
    model_move(phase_at(seq_index(m_prev) + 1), es);
    drive_phase(m_prev, hc, ha);
    checks++; if (hc !== 1 || ha !== LAT || Q !== WIDTH'(m_q)) begin failures++; $display("FAIL filt_edge pulses=%0d at=%0d q=%0h exp 1 at=%0d q=%0h", hc, ha, Q, LAT, m_q); end
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    model_reset(2'b00);
    test_reset();
    test_up();
    test_wrap();
    test_err();
    test_clear_step();
    test_random();
    test_reset_idle();
`ifdef QUAD_FILTER_EN
    test_filter();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
